// File: rtl/ul4_seq.sv
// Accumulator sequencer feeding the 4-bit logic unit: registers operands and select,
// writes the unit's result back into the accumulator and returns it over valid/ready.
module ul4_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    output logic [3:0]       ul_a,
    output logic [3:0]       ul_b,
    output logic [1:0]       ul_s,
    input  logic [3:0]       ul_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_zero,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [3:0]       ul_a_q, ul_a_d;
    logic [3:0]       ul_b_q, ul_b_d;
    logic [1:0]       ul_s_q, ul_s_d;
    logic             cmd_accept;

    // A new command may overlap the result transfer so loads sustain one per cycle.
    assign cmd_ready  = !clr && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && res_ready));
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path infers a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        op_cnt_d = op_cnt_q;
        ul_a_d   = ul_a_q;
        ul_b_d   = ul_b_q;
        ul_s_d   = ul_s_q;

        if (clr) begin
            state_d  = ST_IDLE;
            acc_d    = 4'h0;
            op_cnt_d = '0;
            ul_a_d   = 4'h0;
            ul_b_d   = 4'h0;
            ul_s_d   = 2'b00;
        end else begin
            case (state_q)
                ST_EXEC: begin
                    acc_d    = ul_out;
                    op_cnt_d = op_cnt_q + CNT_W'(1);
                    state_d  = ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) state_d = ST_IDLE;
                end
                ST_IDLE: ;
                default: state_d = ST_IDLE;
            endcase

            // cmd_accept already implies IDLE, or RESP with the result leaving this edge.
            if (cmd_accept) begin
                if (cmd_load) begin
                    acc_d   = cmd_data;
                    state_d = ST_RESP;
                end else begin
                    ul_a_d  = acc_q;
                    ul_b_d  = cmd_data;
                    ul_s_d  = cmd_op;
                    state_d = ST_EXEC;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= 4'h0;
            op_cnt_q <= '0;
            ul_a_q   <= 4'h0;
            ul_b_q   <= 4'h0;
            ul_s_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            op_cnt_q <= op_cnt_d;
            ul_a_q   <= ul_a_d;
            ul_b_q   <= ul_b_d;
            ul_s_q   <= ul_s_d;
        end
    end

    assign ul_a      = ul_a_q;
    assign ul_b      = ul_b_q;
    assign ul_s      = ul_s_q;
    assign res_valid = (state_q == ST_RESP);
    assign res_data  = acc_q;
    assign res_zero  = (acc_q == 4'h0);
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_ul4_seq.sv
// Self-checking bench for ul4_seq: directed scenarios plus randomized streams
// compared against a command-level accumulator model.
module tb_ul4_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] ul_a, ul_b;
    logic [1:0] ul_s;
    logic [3:0] ul_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
    logic [7:0] op_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] mdl_acc;
    logic [7:0] mdl_cnt;

    ul4_seq #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .ul_a(ul_a), .ul_b(ul_b), .ul_s(ul_s), .ul_out(ul_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // The downstream 4-bit logic unit.
    always_comb begin
        case (ul_s)
            2'b00:   ul_out = ~ul_a;
            2'b01:   ul_out = ul_a ^ ul_b;
            2'b10:   ul_out = ul_a | ul_b;
            default: ul_out = ul_a & ul_b;
        endcase
    end

    function automatic logic [3:0] ref_logic(input logic [1:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            2'd0:    return 4'hF - a;
            2'd1:    return a ^ b;
            2'd2:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Applies one command's effect to the model; returns the result it should produce.
    function automatic logic [3:0] model_apply(input logic ld, input logic [1:0] op,
                                               input logic [3:0] d);
        if (ld) mdl_acc = d;
        else begin
            mdl_acc = ref_logic(op, mdl_acc, d);
            mdl_cnt = mdl_cnt + 8'd1;
        end
        return mdl_acc;
    endfunction

    // Offers one command, waits for acceptance, returns at negedge+1 after the accept edge.
    task automatic do_cmd(input logic ld, input logic [1:0] op, input logic [3:0] d);
        int n;
        logic [3:0] r;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_data = d;
        #1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        total_cnt++;
        if (!cmd_ready) $display("FAIL cmd_accept: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        else pass_cnt++;
        @(posedge clk);
        r = model_apply(ld, op, d);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        total_cnt++;
        if (!res_valid) $display("FAIL res_wait: res_valid=%b required 1 within 20 cycles", res_valid);
        else pass_cnt++;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        mdl_acc = 4'h0;
        mdl_cnt = 8'h0;
    endtask

    // mode 0: logic ops, 1: loads, 2: mixed with random gaps and backpressure.
    task automatic run_stream(input int mode, input int n);
        logic [3:0] exp_q[$];
        logic [3:0] r;
        int cyc, n_acc, n_res, prev, gap;
        bit accepted;
        gap = (mode == 1) ? 1 : 2;
        cyc = 0; n_acc = 0; n_res = 0; prev = -1;
        @(negedge clk);
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_load  = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 4'($urandom_range(0, 15));
        while (n_res < n && cyc < 40 * n + 40) begin
            if (mode == 2) res_ready = 1'($urandom_range(0, 1));
            #1;
            accepted = 1'b0;
            if (res_valid && res_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: res_data=%h appeared with no command pending", res_data);
                end else if (res_data !== exp_q[0] || res_zero !== (exp_q[0] == 4'h0)
                             || op_cnt !== mdl_cnt) begin
                    $display("FAIL stream_res #%0d: data=%h zero=%b cnt=%0d required data=%h zero=%b cnt=%0d",
                             n_res, res_data, res_zero, op_cnt, exp_q[0], exp_q[0] == 4'h0, mdl_cnt);
                end else pass_cnt++;
                if (exp_q.size() != 0) exp_q.pop_front();
                if (mode != 2 && prev >= 0) begin
                    total_cnt++;
                    if (cyc - prev !== gap)
                        $display("FAIL stream_gap #%0d: %0d cycles required %0d", n_res, cyc - prev, gap);
                    else pass_cnt++;
                end
                prev = cyc;
                n_res++;
            end
            if (cmd_valid && cmd_ready) begin
                r = model_apply(cmd_load, cmd_op, cmd_data);
                exp_q.push_back(r);
                n_acc++;
                accepted = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (accepted || !cmd_valid) begin
                cmd_valid = (n_acc < n) && ((mode != 2) || ($urandom_range(0, 3) != 0));
                if (accepted) begin
                    cmd_load = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
                    cmd_op   = 2'($urandom_range(0, 3));
                    cmd_data = 4'($urandom_range(0, 15));
                end
            end
        end
        total_cnt++;
        if (n_res != n) $display("FAIL stream_timeout: %0d results required %0d", n_res, n);
        else pass_cnt++;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (res_valid !== 1'b0 || res_data !== 4'h0 || res_zero !== 1'b1 || op_cnt !== 8'h0
            || ul_a !== 4'h0 || ul_b !== 4'h0 || ul_s !== 2'b00 || cmd_ready !== 1'b1)
            $display("FAIL reset_state: valid=%b data=%h zero=%b cnt=%0d a=%h b=%h s=%b rdy=%b required 0 0 1 0 0 0 00 1",
                     res_valid, res_data, res_zero, op_cnt, ul_a, ul_b, ul_s, cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_chain();
        logic [3:0] exp_res [5];
        logic       ld      [5];
        logic [1:0] ops     [5];
        logic [3:0] dat     [5];
        exp_res = '{4'hA, 4'hC, 4'h3, 4'h7, 4'h5};
        ld      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ops     = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
        dat     = '{4'hA, 4'h6, 4'h0, 4'h4, 4'h5};
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_cmd(ld[i], ops[i], dat[i]);
            if (i == 1) begin
                total_cnt++;
                if (ul_a !== 4'hA || ul_b !== 4'h6 || ul_s !== 2'b01)
                    $display("FAIL chain_exec_ul: a=%h b=%h s=%b required a b 01", ul_a, ul_b, ul_s);
                else pass_cnt++;
            end
            wait_res();
            total_cnt++;
            if (res_data !== exp_res[i] || res_data !== mdl_acc || res_zero !== 1'b0)
                $display("FAIL chain_res #%0d: data=%h zero=%b required data=%h zero=0",
                         i, res_data, res_zero, exp_res[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (op_cnt !== 8'd4) $display("FAIL chain_cnt: op_cnt=%0d required 4", op_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        res_ready = 1'b1;
        do_cmd(1'b1, 2'd0, 4'hF);
        wait_res();
        @(negedge clk);
        res_ready = 1'b0;
        do_cmd(1'b0, 2'd1, 4'hF);
        wait_res();
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_op = 2'd0; cmd_data = 4'h9;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++;
            if (res_valid !== 1'b1 || res_data !== 4'h0 || res_zero !== 1'b1 || cmd_ready !== 1'b0)
                $display("FAIL bp_hold #%0d: valid=%b data=%h zero=%b rdy=%b required 1 0 1 0",
                         i, res_valid, res_data, res_zero, cmd_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL bp_release_ready: cmd_ready=%b required 1", cmd_ready);
        else pass_cnt++;
        @(posedge clk);
        mdl_acc = 4'h9;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        total_cnt++;
        if (res_valid !== 1'b1 || res_data !== mdl_acc)
            $display("FAIL bp_next_cmd: valid=%b data=%h required 1 %h", res_valid, res_data, mdl_acc);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_throughput();
        pulse_clr();
        run_stream(0, 10);
        total_cnt++;
        if (op_cnt !== 8'd10) $display("FAIL tp_ops_cnt: op_cnt=%0d required 10", op_cnt);
        else pass_cnt++;
        run_stream(1, 10);
        total_cnt++;
        if (op_cnt !== 8'd10) $display("FAIL tp_loads_cnt: op_cnt=%0d required 10", op_cnt);
        else pass_cnt++;
    endtask

    task automatic test_clr();
        res_ready = 1'b1;
        do_cmd(1'b1, 2'd0, 4'hE);
        wait_res();
        do_cmd(1'b0, 2'd3, 4'h3);
        clr = 1'b1;
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'h5;
        #1;
        total_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL clr_ready: cmd_ready=%b required 0", cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        clr = 1'b0;
        cmd_valid = 1'b0;
        mdl_acc = 4'h0;
        mdl_cnt = 8'h0;
        #1;
        total_cnt++;
        if (res_valid !== 1'b0 || res_data !== 4'h0 || op_cnt !== 8'h0 || ul_s !== 2'b00
            || cmd_ready !== 1'b1)
            $display("FAIL clr_state: valid=%b data=%h cnt=%0d s=%b rdy=%b required 0 0 0 00 1",
                     res_valid, res_data, op_cnt, ul_s, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        res_ready = 1'b1;
        do_cmd(1'b0, 2'd1, 4'h3);
        wait_res();
        @(negedge clk);
        res_ready = 1'b0;
        do_cmd(1'b1, 2'd0, 4'h7);
        wait_res();
        total_cnt++;
        if (res_data !== 4'h7 || ul_s !== 2'b01)
            $display("FAIL arst_pre: data=%h s=%b required 7 01", res_data, ul_s);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (res_valid !== 1'b0 || res_data !== 4'h0 || ul_s !== 2'b00 || res_zero !== 1'b1)
            $display("FAIL arst_now: valid=%b data=%h s=%b zero=%b required 0 0 00 1",
                     res_valid, res_data, ul_s, res_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        mdl_acc = 4'h0;
        mdl_cnt = 8'h0;
    endtask

    task automatic test_wrap();
        pulse_clr();
        run_stream(0, 255);
        total_cnt++;
        if (op_cnt !== 8'd255) $display("FAIL wrap_255: op_cnt=%0d required 255", op_cnt);
        else pass_cnt++;
        run_stream(0, 1);
        total_cnt++;
        if (op_cnt !== 8'd0) $display("FAIL wrap_0: op_cnt=%0d required 0", op_cnt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        run_stream(2, 60);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0;
        cmd_op = 2'd0; cmd_data = 4'h0; res_ready = 1'b1;
        mdl_acc = 4'h0; mdl_cnt = 8'h0;
        test_reset();
        test_chain();
        test_backpressure();
        test_throughput();
        test_clr();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
